// File: rtl/ncpu64k_immu_pkg.sv
// ncpu64k_immu_pkg: TLB entry field positions, flush FSM encoding and msr_immid layout
// shared by the set-associative IMMU files.
package ncpu64k_immu_pkg;
  localparam int TLBL_V   = 0;
  localparam int TLBH_P   = 0;
  localparam int TLBH_UX  = 3;
  localparam int TLBH_RX  = 4;
  localparam int TLBH_UNC = 7;
  localparam int TLBH_S   = 8;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;
  typedef struct packed {
    logic unc;
    logic rx;
    logic ux;
  } perm_t;
  function automatic logic [5:0] immid_fld(input logic [2:0] p_ways, input logic [2:0] p_sets);
    return {p_ways, p_sets};
  endfunction
endpackage

// File: rtl/immu_sa_victim.sv
// immu_sa_victim: refill way selector (tag match > lowest invalid > round-robin)
// owning the per-set round-robin pointers.
module immu_sa_victim #(
  parameter int P_SETS = 5,
  parameter int P_WAYS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_we,
  input  logic [P_SETS-1:0]                     i_set,
  input  logic [(1<<P_WAYS)-1:0]                i_match,
  input  logic [(1<<P_WAYS)-1:0]                i_valid,
  output logic [((P_WAYS > 0) ? P_WAYS : 1)-1:0] o_way
);
  localparam int WAYS = 1 << P_WAYS;
  localparam int SETS = 1 << P_SETS;
  localparam int WW = (P_WAYS > 0) ? P_WAYS : 1;
  logic [WW-1:0] r_rr [SETS];
  logic          w_from_rr;
  logic          w_any_match;
  logic          w_any_inv;
  always_comb begin
    w_any_match = |i_match;
    w_any_inv = ~&i_valid;
    w_from_rr = ~w_any_match & ~w_any_inv;
    o_way = r_rr[i_set];
    for (int i = WAYS - 1; i >= 0; i--)
      if (~w_any_match & ~i_valid[i]) o_way = WW'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (i_match[i]) o_way = WW'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (i_we & w_from_rr) begin
      r_rr[i_set] <= WW'((int'(r_rr[i_set]) + 1) % WAYS);
    end
  end
endmodule

// File: rtl/immu_sa.sv
// immu_sa: set-associative instruction MMU with hardware-assisted refill and flush FSM.
// Optional hit/miss performance counters are built when NCPU_ITLB_PERF_CNT_EN is defined.
module immu_sa
  import ncpu64k_immu_pkg::*;
#(
  parameter int CONFIG_AW = 32,
  parameter int CONFIG_DW = 32,
  parameter int CONFIG_P_PAGE_SIZE = 13,
  parameter int CONFIG_ITLB_P_SETS = 5,
  parameter int CONFIG_ITLB_P_WAYS = 1,
  parameter int CONFIG_IMMU_ENABLE_UNCACHED_SEG = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    re,
  input  logic [CONFIG_AW-CONFIG_P_PAGE_SIZE-1:0] vpn,
  output logic [CONFIG_AW-CONFIG_P_PAGE_SIZE-1:0] ppn,
  output logic                                    EITM,
  output logic                                    EIPF,
  output logic                                    uncached,
  output logic                                    busy,
  input  logic                                    msr_psr_imme,
  input  logic                                    msr_psr_rm,
  output logic [CONFIG_DW-1:0]                    msr_immid,
  input  logic [CONFIG_DW-1:0]                    msr_imm_tlbl_nxt,
  input  logic                                    msr_imm_tlbl_we,
  input  logic [CONFIG_DW-1:0]                    msr_imm_tlbh_nxt,
  input  logic                                    msr_imm_tlbh_we,
  input  logic                                    msr_imm_flush,
  output logic [CONFIG_DW-1:0]                    msr_imm_hit_cnt,
  output logic [CONFIG_DW-1:0]                    msr_imm_miss_cnt
);
  localparam int VPN_DW = CONFIG_AW - CONFIG_P_PAGE_SIZE;
  localparam int SW = CONFIG_ITLB_P_SETS;
  localparam int SETS = 1 << SW;
  localparam int WAYS = 1 << CONFIG_ITLB_P_WAYS;
  localparam int WW = (CONFIG_ITLB_P_WAYS > 0) ? CONFIG_ITLB_P_WAYS : 1;
  logic [WAYS-1:0]   r_v [SETS];
  logic [VPN_DW-1:0] r_tag [WAYS][SETS];
  logic [VPN_DW-1:0] r_ppn [WAYS][SETS];
  perm_t             r_perm [WAYS][SETS];
  logic              r_imme, r_rm;
  logic [VPN_DW-1:0] r_vpn;
  logic [WAYS-1:0]   r_rv;
  logic [VPN_DW-1:0] r_rtag [WAYS];
  logic [VPN_DW-1:0] r_rppn [WAYS];
  perm_t             r_rperm [WAYS];
  logic              r_stg_v;
  logic [VPN_DW-1:0] r_stg_vpn;
  logic [0:0]        r_state;
  logic [SW-1:0]     r_cnt;
  logic              w_busy, w_acc, w_flush_go, w_commit, w_any, w_deny, w_unused;
  logic [SW-1:0]     w_set, w_cset;
  logic [WAYS-1:0]   w_hit, w_cmatch;
  logic [WW-1:0]     w_sel, w_way;
  perm_t             w_perm;
  assign w_busy = r_state == S_FLUSH;
  assign busy = w_busy;
  assign w_acc = re & ~w_busy;
  assign w_set = vpn[SW-1:0];
  assign w_cset = r_stg_vpn[SW-1:0];
  assign w_flush_go = msr_imm_flush & ~w_busy;
  // A flush arriving with the commit wins; commits during a flush are dropped.
  assign w_commit = msr_imm_tlbh_we & r_stg_v & ~w_busy & ~msr_imm_flush;
  assign msr_immid = {{(CONFIG_DW-6){1'b0}},
                      immid_fld(3'(CONFIG_ITLB_P_WAYS), 3'(CONFIG_ITLB_P_SETS))};
  assign w_unused = ^{msr_imm_tlbl_nxt[CONFIG_DW-VPN_DW-1:TLBL_V],
                      msr_imm_tlbh_nxt[CONFIG_DW-VPN_DW-1:TLBH_S],
                      msr_imm_tlbh_nxt[TLBH_UNC-1:TLBH_RX+1],
                      msr_imm_tlbh_nxt[TLBH_UX-1:TLBH_P]};
  always_comb begin
    w_hit = '0;
    w_cmatch = '0;
    w_sel = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_hit[i] = r_rv[i] & (r_rtag[i] == r_vpn);
      w_cmatch[i] = r_v[w_cset][i] & (r_tag[i][w_cset] == r_stg_vpn);
    end
    for (int i = WAYS - 1; i >= 0; i--)
      if (w_hit[i]) w_sel = WW'(i);
  end
  assign w_any = |w_hit;
  assign w_perm = r_rperm[w_sel];
  assign w_deny = r_rm ? ~w_perm.rx : ~w_perm.ux;
  assign EITM = r_imme & ~w_any & ~w_busy;
  assign EIPF = r_imme & w_any & w_deny & ~w_busy;
  assign ppn = (r_imme & w_any) ? r_rppn[w_sel] : r_vpn;
  assign uncached = ~w_busy & ((r_imme & w_any & ~w_deny & w_perm.unc) |
                    ((CONFIG_IMMU_ENABLE_UNCACHED_SEG != 0) & ~EITM & ~EIPF &
                     (ppn[VPN_DW-1 -: 4] == 4'h8)));
  immu_sa_victim #(.P_SETS(SW), .P_WAYS(CONFIG_ITLB_P_WAYS)) u_victim (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_commit),
    .i_set   (w_cset),
    .i_match (w_cmatch),
    .i_valid (r_v[w_cset]),
    .o_way   (w_way)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_v[s] <= '0;
      r_imme <= 1'b0;
      r_rm <= 1'b0;
      r_vpn <= '0;
      r_rv <= '0;
      r_stg_v <= 1'b0;
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      if (w_busy) r_v[r_cnt] <= '0;
      if (w_commit) r_v[w_cset][w_way] <= 1'b1;
      if (w_acc) begin
        r_imme <= msr_psr_imme;
        r_rm <= msr_psr_rm;
        r_vpn <= vpn;
        r_rv <= r_v[w_set];
      end
      r_stg_v <= msr_imm_tlbl_we ? 1'b1 : (msr_imm_tlbh_we | msr_imm_flush) ? 1'b0 : r_stg_v;
      r_state <= w_flush_go ? S_FLUSH : (w_busy & (&r_cnt)) ? S_IDLE : r_state;
      r_cnt <= w_flush_go ? '0 : w_busy ? r_cnt + 1'b1 : r_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (msr_imm_tlbl_we) r_stg_vpn <= msr_imm_tlbl_nxt[CONFIG_DW-1 -: VPN_DW];
    if (w_commit) begin
      r_tag[w_way][w_cset] <= r_stg_vpn;
      r_ppn[w_way][w_cset] <= msr_imm_tlbh_nxt[CONFIG_DW-1 -: VPN_DW];
      r_perm[w_way][w_cset] <= {msr_imm_tlbh_nxt[TLBH_UNC], msr_imm_tlbh_nxt[TLBH_RX],
                                msr_imm_tlbh_nxt[TLBH_UX]};
    end
    if (w_acc) begin
      for (int i = 0; i < WAYS; i++) begin
        r_rtag[i] <= r_tag[i][w_set];
        r_rppn[i] <= r_ppn[i][w_set];
        r_rperm[i] <= r_perm[i][w_set];
      end
    end
  end
`ifdef NCPU_ITLB_PERF_CNT_EN
  logic        r_pend;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_pend <= w_acc & msr_psr_imme;
      r_hit_cnt <= r_hit_cnt + {31'b0, r_pend & w_any};
      r_miss_cnt <= r_miss_cnt + {31'b0, r_pend & ~w_any};
    end
  end
  assign msr_imm_hit_cnt = CONFIG_DW'(r_hit_cnt);
  assign msr_imm_miss_cnt = CONFIG_DW'(r_miss_cnt);
`else
  assign msr_imm_hit_cnt = '0;
  assign msr_imm_miss_cnt = '0;
`endif
endmodule

// File: tb/tb_immu_sa.sv
// tb_immu_sa: directed checks of lookup, refill, victim choice, flush and reset for immu_sa
// (20-bit VPN, 32 sets, 2 ways, uncached segment on).
module tb_immu_sa;
`ifdef NCPU_ITLB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk, rst_n, re;
  logic [19:0] vpn, ppn;
  logic        EITM, EIPF, uncached, busy;
  logic        msr_psr_imme, msr_psr_rm;
  logic [31:0] msr_immid, msr_imm_tlbl_nxt, msr_imm_tlbh_nxt;
  logic        msr_imm_tlbl_we, msr_imm_tlbh_we, msr_imm_flush;
  logic [31:0] msr_imm_hit_cnt, msr_imm_miss_cnt;
  int          n_pass = 0;
  int          n_tot = 0;
  int          n_busy = 0;
  int          busy_start;
  immu_sa #(
    .CONFIG_AW(32), .CONFIG_DW(32), .CONFIG_P_PAGE_SIZE(12),
    .CONFIG_ITLB_P_SETS(5), .CONFIG_ITLB_P_WAYS(1), .CONFIG_IMMU_ENABLE_UNCACHED_SEG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .vpn(vpn), .ppn(ppn),
    .EITM(EITM), .EIPF(EIPF), .uncached(uncached), .busy(busy),
    .msr_psr_imme(msr_psr_imme), .msr_psr_rm(msr_psr_rm), .msr_immid(msr_immid),
    .msr_imm_tlbl_nxt(msr_imm_tlbl_nxt), .msr_imm_tlbl_we(msr_imm_tlbl_we),
    .msr_imm_tlbh_nxt(msr_imm_tlbh_nxt), .msr_imm_tlbh_we(msr_imm_tlbh_we),
    .msr_imm_flush(msr_imm_flush),
    .msr_imm_hit_cnt(msr_imm_hit_cnt), .msr_imm_miss_cnt(msr_imm_miss_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (busy) n_busy++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] mk_h(input logic [19:0] p, input logic rx, input logic ux,
                                       input logic unc);
    return {p, 12'b0} | {24'b0, unc, 2'b00, rx, ux, 3'b001};
  endfunction
  task automatic lookup(input logic im, input logic rm, input logic [19:0] v);
    msr_psr_imme = im;
    msr_psr_rm = rm;
    vpn = v;
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask
  task automatic refill(input logic [19:0] v, input logic [31:0] h);
    msr_imm_tlbl_nxt = {v, 12'h001};
    msr_imm_tlbl_we = 1'b1;
    tick();
    msr_imm_tlbl_we = 1'b0;
    msr_imm_tlbh_nxt = h;
    msr_imm_tlbh_we = 1'b1;
    tick();
    msr_imm_tlbh_we = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) tick();
    chk(tag, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; re = 1'b0; vpn = '0; msr_psr_imme = 1'b0; msr_psr_rm = 1'b0;
    msr_imm_tlbl_nxt = '0; msr_imm_tlbl_we = 1'b0; msr_imm_tlbh_nxt = '0;
    msr_imm_tlbh_we = 1'b0; msr_imm_flush = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ppn", {12'b0, ppn}, 32'h0);
    chk("rst_eitm", {31'b0, EITM}, 32'd0);
    chk("rst_eipf", {31'b0, EIPF}, 32'd0);
    chk("rst_unc", {31'b0, uncached}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hit_cnt", msr_imm_hit_cnt, 32'd0);
    chk("rst_miss_cnt", msr_imm_miss_cnt, 32'd0);
    chk("immid", msr_immid, 32'h0000_000D);
    lookup(1'b0, 1'b0, 20'h12345);
    chk("off_ppn", {12'b0, ppn}, 32'h12345);
    chk("off_eitm", {31'b0, EITM}, 32'd0);
    chk("off_unc", {31'b0, uncached}, 32'd0);
    lookup(1'b0, 1'b0, 20'h80001);
    chk("seg_ppn", {12'b0, ppn}, 32'h80001);
    chk("seg_unc", {31'b0, uncached}, 32'd1);
    lookup(1'b1, 1'b0, 20'h00400);
    chk("miss_eitm", {31'b0, EITM}, 32'd1);
    chk("miss_eipf", {31'b0, EIPF}, 32'd0);
    tick();
    chk("miss_cnt1", msr_imm_miss_cnt, PERF ? 32'd1 : 32'd0);
    chk("hit_cnt0", msr_imm_hit_cnt, 32'd0);
    refill(20'h00020, mk_h(20'h11111, 1'b1, 1'b1, 1'b0));
    refill(20'h00040, mk_h(20'h22222, 1'b1, 1'b1, 1'b0));
    refill(20'h00060, mk_h(20'h33333, 1'b1, 1'b1, 1'b0));
    lookup(1'b1, 1'b0, 20'h00060);
    chk("rr_60_eitm", {31'b0, EITM}, 32'd0);
    chk("rr_60_ppn", {12'b0, ppn}, 32'h33333);
    chk("rr_60_unc", {31'b0, uncached}, 32'd0);
    lookup(1'b1, 1'b0, 20'h00040);
    chk("rr_40_eitm", {31'b0, EITM}, 32'd0);
    chk("rr_40_ppn", {12'b0, ppn}, 32'h22222);
    lookup(1'b1, 1'b0, 20'h00020);
    chk("rr_20_eitm", {31'b0, EITM}, 32'd1);
    refill(20'h00101, mk_h(20'h07777, 1'b1, 1'b0, 1'b0));
    lookup(1'b1, 1'b0, 20'h00101);
    chk("user_eipf", {31'b0, EIPF}, 32'd1);
    chk("user_eitm", {31'b0, EITM}, 32'd0);
    lookup(1'b1, 1'b1, 20'h00101);
    chk("root_ppn", {12'b0, ppn}, 32'h07777);
    chk("root_eipf", {31'b0, EIPF}, 32'd0);
    chk("root_eitm", {31'b0, EITM}, 32'd0);
    refill(20'h00202, mk_h(20'h00ABC, 1'b0, 1'b1, 1'b1));
    lookup(1'b1, 1'b0, 20'h00202);
    chk("unc_bit", {31'b0, uncached}, 32'd1);
    chk("unc_ppn", {12'b0, ppn}, 32'h00ABC);
    busy_start = n_busy;
    msr_imm_flush = 1'b1;
    tick();
    msr_imm_flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd1);
    chk("flush_unc_gated", {31'b0, uncached}, 32'd0);
    refill(20'h00300, mk_h(20'h04444, 1'b1, 1'b1, 1'b0));
    wait_idle("flush_end");
    chk("flush_len", n_busy - busy_start, 32'd32);
    lookup(1'b1, 1'b0, 20'h00060);
    chk("fl_60", {31'b0, EITM}, 32'd1);
    lookup(1'b1, 1'b0, 20'h00040);
    chk("fl_40", {31'b0, EITM}, 32'd1);
    lookup(1'b1, 1'b1, 20'h00101);
    chk("fl_101", {31'b0, EITM}, 32'd1);
    lookup(1'b1, 1'b0, 20'h00300);
    chk("busy_commit_lost", {31'b0, EITM}, 32'd1);
    msr_imm_tlbl_nxt = {20'h00500, 12'h001};
    msr_imm_tlbl_we = 1'b1;
    tick();
    msr_imm_tlbl_we = 1'b0;
    msr_imm_tlbh_nxt = mk_h(20'h05555, 1'b1, 1'b1, 1'b0);
    msr_imm_tlbh_we = 1'b1;
    msr_imm_flush = 1'b1;
    tick();
    msr_imm_tlbh_we = 1'b0;
    msr_imm_flush = 1'b0;
    wait_idle("flush2_end");
    msr_imm_tlbh_we = 1'b1;
    tick();
    msr_imm_tlbh_we = 1'b0;
    lookup(1'b1, 1'b0, 20'h00500);
    chk("flush_commit_lost", {31'b0, EITM}, 32'd1);
    refill(20'h00500, mk_h(20'h05555, 1'b1, 1'b1, 1'b0));
    lookup(1'b1, 1'b0, 20'h00500);
    chk("refill_after_eitm", {31'b0, EITM}, 32'd0);
    chk("refill_after_ppn", {12'b0, ppn}, 32'h05555);
    tick();
    chk("hit_cnt", msr_imm_hit_cnt, PERF ? 32'd6 : 32'd0);
    chk("miss_cnt", msr_imm_miss_cnt, PERF ? 32'd7 : 32'd0);
    refill(20'h00700, mk_h(20'h06666, 1'b1, 1'b1, 1'b0));
    msr_imm_flush = 1'b1;
    tick();
    msr_imm_flush = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ppn", {12'b0, ppn}, 32'h0);
    chk("arst_hit_cnt", msr_imm_hit_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    lookup(1'b1, 1'b0, 20'h00700);
    chk("arst_v_cleared", {31'b0, EITM}, 32'd1);
    chk("arst_idle", {31'b0, busy}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/immu_sa.md
# immu_sa

Set-associative instruction MMU for the ncpu64k fetch front-end. It is the parametrised successor of the direct-mapped IMMU and translates a fetch VPN into a PPN one cycle after `re`, raising EITM (TLB miss) or EIPF (permission fault). Refill is hardware-assisted: an MSR TLBL/TLBH write pair commits into a victim way chosen in hardware. A flush FSM invalidates all entries and holds the front-end while it runs.

## Interface
- CONFIG_AW, 32, address width
- CONFIG_DW, 32, MSR/entry word width
- CONFIG_P_PAGE_SIZE, 13, log2 page size; VPN_DW = PPN_DW = CONFIG_AW-CONFIG_P_PAGE_SIZE
- CONFIG_ITLB_P_SETS, 5, log2 sets; must be ≤ VPN_DW
- CONFIG_ITLB_P_WAYS, 1, log2 ways (0..3)
- CONFIG_IMMU_ENABLE_UNCACHED_SEG, 1, PPN[top 4]==4'h8 is uncached

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- re  in  1  lookup request; ignored while busy
- vpn  in  VPN_DW  fetch VPN
- ppn  out  VPN_DW  translated PPN; equals the registered VPN when the MMU is off
- EITM, EIPF, uncached  out  1 each  lookup result
- busy  out  1  flush in progress
- msr_psr_imme, msr_psr_rm  in  1 each  MMU enable, root mode
- msr_immid  out  CONFIG_DW  {0, P_WAYS[2:0], P_SETS[2:0]}
- msr_imm_tlbl_nxt, msr_imm_tlbl_we  in  DW, 1  stage the TLBL word
- msr_imm_tlbh_nxt, msr_imm_tlbh_we  in  DW, 1  commit the TLBH word
- msr_imm_flush  in  1  invalidate-all pulse
- msr_imm_hit_cnt, msr_imm_miss_cnt  out  DW each  performance counters

## Operation
- Entry format:
  - TLBL: V=[0], VPN=[DW-1:DW-VPN_DW]
  - TLBH: P=[0], UX=[3], RX=[4], UNC=[7], S=[8], PPN=[DW-1:DW-PPN_DW]
- Storage:
  - V bits live in a flop array (sets × ways) so they can be cleared.
  - TLBL and TLBH data live in per-way `mRF_nwnr`.
- Lookup:
  - On `re & ~busy`, register imme, rm and vpn.
  - Read every way at set = vpn[P_SETS-1:0].
  - hit_w = V & (tag == vpn_ff). The lowest hitting way is selected.
- EITM = imme_ff & ~any_hit.
- EIPF = imme_ff & any_hit & ((rm_ff & ~RX) | (~rm_ff & ~UX)).
- uncached = (imme_ff & any_hit & ~perm_denied & UNC) | (UNCACHED_SEG & ~EITM & ~EIPF & ppn[top4]==4'h8).
- Refill:
  - `tlbl_we` loads the staging register and sets `stg_v`.
  - `tlbh_we` with `stg_v` commits, with set = staged VPN low bits.
  - Way choice, in priority order: a way whose tag matches with V=1 (overwrite), else the lowest invalid way, else `rr_ptr[set]`.
  - The commit sets V, clears `stg_v` and advances `rr_ptr[set]` only if the victim came from `rr_ptr`.
  - `tlbh_we` without `stg_v` is dropped.
- Flush FSM, states IDLE → FLUSH → IDLE:
  - `msr_imm_flush` in IDLE enters FLUSH with cnt=0 and busy=1.
  - Each FLUSH cycle clears V for all ways of set cnt and increments cnt.
  - After the last set (cnt = 2^P_SETS-1) the FSM returns to IDLE. Flush takes exactly 2^P_SETS cycles.
  - A flush pulse during FLUSH is ignored.
- Simultaneous events:
  - flush and commit in the same cycle: flush wins, the commit is discarded and `stg_v` is cleared.
  - commit while busy: discarded.
  - commit and a lookup of the same set in the same cycle: the lookup sees the old contents.
- While busy, EITM/EIPF/uncached are 0.

## Timing
- Lookup latency is 1: outputs are valid in the cycle after `re` and hold until the next accepted `re`.
- Reset values: V array 0, rr_ptr 0, stg_v 0, FSM IDLE, busy 0, imme_ff/rm_ff/vpn_ff 0. Resulting outputs: ppn 0, EITM 0, EIPF 0, uncached 0, counters 0.
- Asserting rst_n low mid-flush returns the FSM to IDLE immediately with V cleared.
- A committed entry is visible to a lookup whose `re` arrives the cycle after the commit.

## Configuration
- NCPU_ITLB_PERF_CNT_EN, when defined:
  - 32-bit wrapping counters for hit and miss.
  - They count once per accepted lookup with imme=1, one cycle after it.
- When undefined, both counter outputs are tied to 0 and no counter flops exist.

## Structure
- Shared package ncpu64k_immu_pkg holds:
  - the TLBL/TLBH field bit positions
  - the FSM state encoding
  - the msr_immid layout
- One natural sub-module, immu_sa_victim: a combinational way selector (match > invalid > rr) owning the per-set rr_ptr flops.

## Test plan
- Reset, imme=0, re with vpn=0x12345 → next cycle ppn=0x12345, EITM=0. With UNCACHED_SEG set, ppn=0x80001 → uncached=1.
- imme=1, empty TLB, re vpn=0x00400 → EITM=1, EIPF=0; miss_cnt=1 when NCPU_ITLB_PERF_CNT_EN is defined.
- Two-way TLB (P_WAYS=1), refill VPNs 0x00020 and 0x00040 (same set 0), then a third 0x00060 → both 0x00060 and 0x00040 hit, 0x00020 misses (rr victim way 0).
- Refill an entry with RX=1, UX=0, PPN=0x7777; lookup in user mode → EIPF=1, EITM=0. Same lookup in root mode → ppn=0x7777, no exceptions.
- Flush with P_SETS=5 → busy high for exactly 32 cycles, then all prior entries miss. A commit issued during busy is lost.
- Flush and commit in the same cycle → the entry is absent afterwards and a following `tlbh_we` alone is dropped.
